// File: rtl/jtkcpu_idxseq.sv
// jtkcpu_idxseq: computes the effective address for KCPU indexed addressing.
//   Decodes the indexed postbyte, fetches 0/1/2 offset bytes from the
//   instruction stream and adds the offset to the selected base register.
//   It also produces the auto inc/dec write-back and performs the optional
//   indirect pointer fetch.
// Optional build macro: JTKCPU_IDXSEQ_ILLEGAL_EN enables illegal-postbyte
//   detection. When it is undefined, illegal is tied low, modes 7/A/E act
//   as ,R, invalid indirect bits are ignored, and mode F without indirect
//   acts as extended direct.
// Ports:
//   clk, rst_n, cen       clock, async active-low reset, clock enable
//   start, postbyte       begin a sequence with this postbyte (latched)
//   regsel, idx_reg       base register select / value of that register
//   acc_a, acc_b          accumulators for B,R  A,R  D,R
//   pc, pc_inc            stream pointer / one byte consumed
//   bus_req/addr/din/ack  memory read port
//   reg_wr, reg_wdata     auto inc/dec write-back to the regsel register
//   ea, busy, done, illegal  result and status
module jtkcpu_idxseq #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [7:0]    postbyte,
  output logic [1:0]    regsel,
  input  logic [AW-1:0] idx_reg,
  input  logic [7:0]    acc_a,
  input  logic [7:0]    acc_b,
  input  logic [AW-1:0] pc,
  output logic          pc_inc,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_din,
  input  logic          bus_ack,
  output logic          reg_wr,
  output logic [AW-1:0] reg_wdata,
  output logic [AW-1:0] ea,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  typedef enum logic [2:0] {
    IDLE, OFS_HI, OFS_LO, CALC, IND_HI, IND_LO, FIN
  } state_t;

  typedef struct packed {
    logic       ill;
    logic       ind;
    logic [1:0] nb;   // offset bytes to fetch
  } dec_t;

  function automatic dec_t decode(input logic [7:0] pb);
    dec_t       d;
    logic [3:0] m;
    logic       bad_ind;
    d       = '0;
    m       = pb[3:0];
    bad_ind = (m == 4'h0) || (m == 4'h2);
    if (pb[7]) begin
      case (m)
        4'h8, 4'hC:       d.nb = 2'd1;
        4'h9, 4'hD, 4'hF: d.nb = 2'd2;
        default:          d.nb = 2'd0;
      endcase
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
      d.ind = pb[4];
      d.ill = (m == 4'h7) || (m == 4'hA) || (m == 4'hE) ||
              (bad_ind && pb[4]) || ((m == 4'hF) && !pb[4]);
`else
      d.ind = pb[4] && !bad_ind;
`endif
    end
    return d;
  endfunction

  state_t        state, nxt;
  logic [7:0]    pb_q;
  logic [AW-1:0] ofs_q, ea_q;
  logic [7:0]    hi_q;
  logic          ill_q, ind_q;
  dec_t          d_in;
  logic [AW-1:0] calc_ea, wb_val, ofs8;
  logic          wb;

  assign d_in    = decode(postbyte);
  assign regsel  = pb_q[6:5];
  assign ea      = ea_q;
  assign done    = (state == FIN);
  assign busy    = (state != IDLE) && (state != FIN);
  assign illegal = (state == FIN) && ill_q;
  assign ofs8    = {{(AW-8){ofs_q[7]}}, ofs_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pb_q  <= '0;
      ofs_q <= '0;
      ea_q  <= '0;
      hi_q  <= '0;
      ill_q <= 1'b0;
      ind_q <= 1'b0;
    end else if (cen) begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          pb_q  <= postbyte;
          ofs_q <= '0;
          ea_q  <= '0;
          ill_q <= d_in.ill;
          ind_q <= d_in.ind;
        end
        OFS_HI: if (bus_ack) ofs_q[15:8] <= bus_din;
        OFS_LO: if (bus_ack) ofs_q[7:0]  <= bus_din;
        CALC:   ea_q <= calc_ea;
        IND_HI: if (bus_ack) hi_q <= bus_din;
        IND_LO: if (bus_ack) ea_q <= {hi_q, bus_din};
        default: ;
      endcase
    end
  end

  // Address arithmetic for CALC, from the latched postbyte
  always_comb begin
    calc_ea = idx_reg;
    wb      = 1'b0;
    wb_val  = '0;
    if (!pb_q[7]) begin
      calc_ea = idx_reg + {{(AW-5){pb_q[4]}}, pb_q[4:0]};
    end else begin
      case (pb_q[3:0])
        4'h0: begin wb = 1'b1; wb_val = idx_reg + AW'(1); end
        4'h1: begin wb = 1'b1; wb_val = idx_reg + AW'(2); end
        4'h2: begin calc_ea = idx_reg - AW'(1); wb = 1'b1; wb_val = calc_ea; end
        4'h3: begin calc_ea = idx_reg - AW'(2); wb = 1'b1; wb_val = calc_ea; end
        4'h5: calc_ea = idx_reg + {{(AW-8){acc_b[7]}}, acc_b};
        4'h6: calc_ea = idx_reg + {{(AW-8){acc_a[7]}}, acc_a};
        4'h8: calc_ea = idx_reg + ofs8;
        4'h9: calc_ea = idx_reg + ofs_q;
        4'hB: calc_ea = idx_reg + {acc_a, acc_b};
        4'hC: calc_ea = pc + ofs8;
        4'hD: calc_ea = pc + ofs_q;
        4'hF: calc_ea = ofs_q;
        default: calc_ea = idx_reg;
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    bus_req   = 1'b0;
    bus_addr  = '0;
    pc_inc    = 1'b0;
    reg_wr    = 1'b0;
    reg_wdata = '0;
    case (state)
      IDLE: if (start) begin
        if (d_in.ill)            nxt = FIN;
        else if (d_in.nb == 2'd2) nxt = OFS_HI;
        else if (d_in.nb == 2'd1) nxt = OFS_LO;
        else                     nxt = CALC;
      end
      OFS_HI: begin
        bus_req  = 1'b1;
        bus_addr = pc;
        if (bus_ack) begin pc_inc = 1'b1; nxt = OFS_LO; end
      end
      OFS_LO: begin
        bus_req  = 1'b1;
        bus_addr = pc;
        if (bus_ack) begin pc_inc = 1'b1; nxt = CALC; end
      end
      CALC: begin
        reg_wr    = wb;
        reg_wdata = wb_val;
        nxt       = ind_q ? IND_HI : FIN;
      end
      IND_HI: begin
        bus_req  = 1'b1;
        bus_addr = ea_q;
        if (bus_ack) nxt = IND_LO;
      end
      IND_LO: begin
        bus_req  = 1'b1;
        bus_addr = ea_q + AW'(1);
        if (bus_ack) nxt = FIN;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

endmodule
